clint_responder: RTL and testbench

//  Bus responder for the core-local interruptor. Sits on the core's memory bus
//  (rd_en/wr_en/byte_en/busy protocol) and drives the core's mem_msip, mem_ssip,
//  mem_mtime and mem_mtimecmp inputs.

---
 rtl/clint_responder_if.sv | 16 +
 rtl/clint_responder.sv | 143 ++++++++++++++
 tb/tb_clint_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clint_responder_if.sv
// Memory-bus bundle between the core and the CLINT responder.
// rd_en/wr_en/byte_en request with a busy handshake; DATA_SIZE is 32 or 64.
interface clint_responder_if #(
    parameter int DATA_SIZE = 32
);
    logic [15:0]            addr;
    logic [DATA_SIZE-1:0]   wr_data;
    logic [DATA_SIZE-1:0]   rd_data;
    logic                   rd_en;
    logic                   wr_en;
    logic [DATA_SIZE/8-1:0] byte_en;
    logic                   busy;

    modport master (output addr, wr_data, rd_en, wr_en, byte_en, input rd_data, busy);
    modport slave  (input addr, wr_data, rd_en, wr_en, byte_en, output rd_data, busy);
endinterface

// File: rtl/clint_responder.sv
// Core-local interruptor responder: msip/ssip bits, free-running mtime, mtimecmp.
// Define CLINT_SSIP_EN to implement the ssip register at 0x0004.
module clint_responder #(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    clint_responder_if.slave        bus,
    output logic                    msip,
    output logic                    ssip,
    output logic [63:0]             mtime,
    output logic [63:0]             mtimecmp
);
    localparam int BE_W = DATA_SIZE / 8;
    localparam int PW   = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;

    // Addresses are decoded as 64-bit word indices (addr[15:3]).
    localparam logic [12:0] WORD_SIP  = 13'h0000;
    localparam logic [12:0] WORD_CMP  = 13'h0800;
    localparam logic [12:0] WORD_TIME = 13'h17FF;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t               state, state_next;
    logic                 req, load, busy_c;
    logic [12:0]          lat_word;
    logic [DATA_SIZE-1:0] lat_data;
    logic [BE_W-1:0]      lat_be;
    logic                 lat_wr;
    logic [DATA_SIZE-1:0] rd_q, rd_value;
    logic [63:0]          wdata_w, read_w;
    logic [7:0]           bmask_w;
    logic                 sel_sip, sel_cmp, sel_time, do_wr, mtime_wr, tick;
    logic [PW-1:0]        prescaler;

    assign req         = bus.rd_en | bus.wr_en;
    assign bus.busy    = busy_c;
    assign bus.rd_data = rd_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        busy_c     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                busy_c = req;
                if (req) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY:    begin busy_c = 1'b1; state_next = ACK; end
            ACK:     if (!req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_word <= '0;
            lat_data <= '0;
            lat_be   <= '0;
            lat_wr   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                lat_word <= bus.addr[15:3];
                lat_data <= bus.wr_data;
                lat_be   <= bus.byte_en;
                lat_wr   <= bus.wr_en;
            end
        end
    end

    // Steer the bus word into a 64-bit register view with a per-byte mask.
    if (DATA_SIZE == 64) begin : g_bus64
        assign wdata_w  = lat_data;
        assign bmask_w  = lat_be;
        assign rd_value = read_w;
    end else begin : g_bus32
        logic lat_hi;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset)    lat_hi <= 1'b0;
            else if (load) lat_hi <= bus.addr[2];
        end
        assign wdata_w  = {lat_data, lat_data};
        assign bmask_w  = lat_hi ? {lat_be, 4'b0000} : {4'b0000, lat_be};
        assign rd_value = lat_hi ? read_w[63:32] : read_w[31:0];
    end

    assign sel_sip  = (lat_word == WORD_SIP);
    assign sel_cmp  = (lat_word == WORD_CMP);
    assign sel_time = (lat_word == WORD_TIME);
    assign do_wr    = (state == BUSY) && lat_wr;
    assign mtime_wr = do_wr && sel_time && (|bmask_w);

    always_comb begin
        read_w = '0;
        if (sel_sip)       read_w = {31'b0, ssip, 31'b0, msip};
        else if (sel_cmp)  read_w = mtimecmp;
        else if (sel_time) read_w = mtime;
    end

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    assign tick = (prescaler == PW'(CLOCK_CYCLES_PER_TICK - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q      <= '0;
            msip      <= 1'b0;
            mtime     <= '0;
            mtimecmp  <= '1;
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (state == BUSY) rd_q <= lat_wr ? '0 : rd_value;
            if (do_wr && sel_sip && bmask_w[0]) msip <= wdata_w[0];
            if (do_wr && sel_cmp) mtimecmp <= merge(mtimecmp, wdata_w, bmask_w);
            // A software write to mtime suppresses that cycle's increment.
            if (mtime_wr)  mtime <= merge(mtime, wdata_w, bmask_w);
            else if (tick) mtime <= mtime + 64'd1;
        end
    end

`ifdef CLINT_SSIP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                              ssip <= 1'b0;
        else if (do_wr && sel_sip && bmask_w[4]) ssip <= wdata_w[32];
    end
`else
    assign ssip = 1'b0;
`endif
endmodule

// File: tb/tb_clint_responder.sv
// Directed bench for clint_responder: 32-bit bus with 4-cycle tick, 64-bit bus with 1-cycle tick.
// Expected read data goes through a scoreboard queue; checks are immediate assertions.
module tb_clint_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

`ifdef CLINT_SSIP_EN
    localparam logic SSIP_EXP = 1'b1;
`else
    localparam logic SSIP_EXP = 1'b0;
`endif

    clint_responder_if #(.DATA_SIZE(32)) bus_a ();
    clint_responder_if #(.DATA_SIZE(64)) bus_b ();

    logic        msip_a, ssip_a, msip_b, ssip_b;
    logic [63:0] mtime_a, mtimecmp_a, mtime_b, mtimecmp_b;

    clint_responder #(.DATA_SIZE(32), .CLOCK_CYCLES_PER_TICK(4)) u_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave),
        .msip(msip_a), .ssip(ssip_a), .mtime(mtime_a), .mtimecmp(mtimecmp_a));

    clint_responder #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(1)) u_b (
        .clock(clock), .reset(reset), .bus(bus_b.slave),
        .msip(msip_b), .ssip(ssip_b), .mtime(mtime_b), .mtimecmp(mtimecmp_b));

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb[$];
    logic [63:0] ack_t, post_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus_a.rd_en = 1'b0; bus_a.wr_en = 1'b0; bus_a.addr = '0; bus_a.wr_data = '0; bus_a.byte_en = '0;
        bus_b.rd_en = 1'b0; bus_b.wr_en = 1'b0; bus_b.addr = '0; bus_b.wr_data = '0; bus_b.byte_en = '0;
    endtask

    // One complete handshake; busy timing is checked every time, read data via scoreboard.
    task automatic access(input bit b64, input bit rd, input bit wr, input logic [15:0] a,
                          input logic [63:0] d, input logic [7:0] be, input logic [63:0] exp_rd,
                          output logic [63:0] ack_mtime, output logic [63:0] post_mtime);
        logic [63:0] exp;
        @(negedge clock);
        if (b64) begin
            bus_b.addr = a; bus_b.wr_data = d; bus_b.byte_en = be;
            bus_b.rd_en = rd; bus_b.wr_en = wr;
        end else begin
            bus_a.addr = a; bus_a.wr_data = d[31:0]; bus_a.byte_en = be[3:0];
            bus_a.rd_en = rd; bus_a.wr_en = wr;
        end
        sb.push_back(exp_rd);
        #1 check("busy_req", 64'(b64 ? bus_b.busy : bus_a.busy), 64'd1);
        @(posedge clock);
        #1 check("busy_busy", 64'(b64 ? bus_b.busy : bus_a.busy), 64'd1);
        @(posedge clock);
        #1 check("busy_ack", 64'(b64 ? bus_b.busy : bus_a.busy), 64'd0);
        exp = sb.pop_front();
        check("rd_data", b64 ? bus_b.rd_data : {32'b0, bus_a.rd_data}, exp);
        ack_mtime = b64 ? mtime_b : mtime_a;
        @(negedge clock);
        bus_idle();
        @(posedge clock);
        #1 post_mtime = b64 ? mtime_b : mtime_a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_mtime",    mtime_a,    64'd0);
        check("rst_mtimecmp", mtimecmp_a, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_msip",     64'(msip_a), 64'd0);
        check("rst_ssip",     64'(ssip_a), 64'd0);
        check("rst_busy",     64'(bus_a.busy), 64'd0);
        check("rst_rd_data",  64'(bus_a.rd_data), 64'd0);
        check("rst_mtimecmp_b", mtimecmp_b, 64'hFFFF_FFFF_FFFF_FFFF);

        // Prescaler of 4: forty idle cycles give ten ticks.
        repeat (40) @(posedge clock);
        #1 check("tick_40", mtime_a, 64'd10);

        // msip write and read-back; reserved bits read as zero.
        access(0, 0, 1, 16'h0000, 64'h3, 8'hF, 64'd0, ack_t, post_t);
        check("msip_set", 64'(msip_a), 64'd1);
        access(0, 1, 0, 16'h0000, 64'h0, 8'h0, 64'd1, ack_t, post_t);
        access(0, 0, 1, 16'h0000, 64'h0, 8'h0, 64'd0, ack_t, post_t);
        check("msip_be0", 64'(msip_a), 64'd1);
        access(0, 1, 1, 16'h0000, 64'h0, 8'hF, 64'd0, ack_t, post_t);
        check("msip_rdwr", 64'(msip_a), 64'd0);

        // Byte-lane writes to mtimecmp halves.
        access(0, 0, 1, 16'h4000, 64'h0000_AB00, 8'h2, 64'd0, ack_t, post_t);
        check("cmp_lo_byte", mtimecmp_a, 64'hFFFF_FFFF_FFFF_ABFF);
        access(0, 0, 1, 16'h4004, 64'h1234_5678, 8'h9, 64'd0, ack_t, post_t);
        check("cmp_hi_byte", mtimecmp_a, 64'h12FF_FF78_FFFF_ABFF);
        access(0, 1, 0, 16'h4004, 64'h0, 8'h0, 64'h12FF_FF78, ack_t, post_t);
        access(0, 1, 0, 16'h4000, 64'h0, 8'h0, 64'hFFFF_ABFF, ack_t, post_t);

        // Unmapped read, ssip, and the upper mtime half.
        access(0, 1, 0, 16'h1234, 64'h0, 8'h0, 64'd0, ack_t, post_t);
        access(0, 0, 1, 16'h0004, 64'h1, 8'hF, 64'd0, ack_t, post_t);
        check("ssip_a", 64'(ssip_a), 64'(SSIP_EXP));
        access(0, 1, 0, 16'h0004, 64'h0, 8'h0, 64'(SSIP_EXP), ack_t, post_t);
        access(0, 1, 0, 16'hBFFC, 64'h0, 8'h0, 64'd0, ack_t, post_t);

        // 64-bit bus: mtime write wins over the tick, then wraps to zero.
        access(1, 0, 1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, ack_t, post_t);
        check("mtime64_ack",  ack_t,  64'hFFFF_FFFF_FFFF_FFFF);
        check("mtime64_wrap", post_t, 64'd0);
        access(1, 0, 1, 16'h0000, 64'h0000_0001_0000_0001, 8'hFF, 64'd0, ack_t, post_t);
        check("msip_b", 64'(msip_b), 64'd1);
        check("ssip_b", 64'(ssip_b), 64'(SSIP_EXP));
        access(1, 1, 0, 16'h0000, 64'h0, 8'h0, {31'b0, SSIP_EXP, 31'b0, 1'b1}, ack_t, post_t);
        access(1, 1, 0, 16'h4000, 64'h0, 8'h0, 64'hFFFF_FFFF_FFFF_FFFF, ack_t, post_t);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
